// File: rtl/hop_stage.sv
// Hop stage: moves each live photon along its direction cosines by the approved step,
// saturating the position, and clears the consumed step fields.
module hop_stage #(
    parameter int BIT_WIDTH    = 32,
    parameter int LAYER_WIDTH  = 3,
    parameter int MULT_LATENCY = 1,
    parameter logic signed [BIT_WIDTH-1:0] INTMAX = 32'sh7FFF_FFFF,
    parameter logic signed [BIT_WIDTH-1:0] INTMIN = 32'sh8000_0000,
    parameter int LATENCY      = MULT_LATENCY + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [BIT_WIDTH-1:0]   x_boundaryChecker,
    input  logic [BIT_WIDTH-1:0]   y_boundaryChecker,
    input  logic [BIT_WIDTH-1:0]   z_boundaryChecker,
    input  logic [BIT_WIDTH-1:0]   ux_boundaryChecker,
    input  logic [BIT_WIDTH-1:0]   uy_boundaryChecker,
    input  logic [BIT_WIDTH-1:0]   uz_boundaryChecker,
    input  logic [BIT_WIDTH-1:0]   sz_boundaryChecker,
    input  logic [BIT_WIDTH-1:0]   sr_boundaryChecker,
    input  logic [BIT_WIDTH-1:0]   sleftz_boundaryChecker,
    input  logic [BIT_WIDTH-1:0]   sleftr_boundaryChecker,
    input  logic [LAYER_WIDTH-1:0] layer_boundaryChecker,
    input  logic [BIT_WIDTH-1:0]   weight_boundaryChecker,
    input  logic                   dead_boundaryChecker,
    input  logic                   hit_boundaryChecker,
    output logic [BIT_WIDTH-1:0]   x_hop,
    output logic [BIT_WIDTH-1:0]   y_hop,
    output logic [BIT_WIDTH-1:0]   z_hop,
    output logic [BIT_WIDTH-1:0]   ux_hop,
    output logic [BIT_WIDTH-1:0]   uy_hop,
    output logic [BIT_WIDTH-1:0]   uz_hop,
    output logic [BIT_WIDTH-1:0]   sz_hop,
    output logic [BIT_WIDTH-1:0]   sr_hop,
    output logic [BIT_WIDTH-1:0]   sleftz_hop,
    output logic [BIT_WIDTH-1:0]   sleftr_hop,
    output logic [LAYER_WIDTH-1:0] layer_hop,
    output logic [BIT_WIDTH-1:0]   weight_hop,
    output logic                   dead_hop,
    output logic                   hit_hop,
    output logic [31:0]            hop_count
);
    typedef struct packed {
        logic [BIT_WIDTH-1:0]   x, y, z, ux, uy, uz, sz, sr, sleftz, sleftr;
        logic [LAYER_WIDTH-1:0] layer;
        logic [BIT_WIDTH-1:0]   weight;
        logic                   dead;
        logic                   hit;
    } bundle_t;

    function automatic bundle_t rst_bundle();
        bundle_t b;
        b      = '0;
        b.dead = 1'b1;
        return b;
    endfunction

    // Q1.31 scaling: keep product bits [2W-2:W-1], i.e. arithmetic >> (W-1).
    function automatic logic [BIT_WIDTH-1:0] qmul(input logic [BIT_WIDTH-1:0] a,
                                                   input logic [BIT_WIDTH-1:0] b);
        logic [2*BIT_WIDTH-1:0] p;
        p = {{BIT_WIDTH{a[BIT_WIDTH-1]}}, a} * {{BIT_WIDTH{b[BIT_WIDTH-1]}}, b};
        return BIT_WIDTH'(p >> (BIT_WIDTH - 1));
    endfunction

    function automatic logic [BIT_WIDTH-1:0] sat_add(input logic [BIT_WIDTH-1:0] a,
                                                      input logic [BIT_WIDTH-1:0] d);
        logic [BIT_WIDTH:0] s;
        s = {a[BIT_WIDTH-1], a} + {d[BIT_WIDTH-1], d};
        if (s[BIT_WIDTH] != s[BIT_WIDTH-1])
            return s[BIT_WIDTH] ? INTMIN : INTMAX;
        return s[BIT_WIDTH-1:0];
    endfunction

    bundle_t              in_b, nxt, out_q;
    bundle_t              bnd_pipe [MULT_LATENCY];
    logic [BIT_WIDTH-1:0] dx_pipe  [MULT_LATENCY];
    logic [BIT_WIDTH-1:0] dy_pipe  [MULT_LATENCY];
    logic [BIT_WIDTH-1:0] dz_pipe  [MULT_LATENCY];

    always_comb begin
        in_b = '{x: x_boundaryChecker, y: y_boundaryChecker, z: z_boundaryChecker,
                 ux: ux_boundaryChecker, uy: uy_boundaryChecker, uz: uz_boundaryChecker,
                 sz: sz_boundaryChecker, sr: sr_boundaryChecker,
                 sleftz: sleftz_boundaryChecker, sleftr: sleftr_boundaryChecker,
                 layer: layer_boundaryChecker, weight: weight_boundaryChecker,
                 dead: dead_boundaryChecker, hit: hit_boundaryChecker};
    end

    // Dead slots pass through untouched, step fields included.
    always_comb begin
        nxt = bnd_pipe[MULT_LATENCY-1];
        if (!nxt.dead) begin
            nxt.x  = sat_add(nxt.x, dx_pipe[MULT_LATENCY-1]);
            nxt.y  = sat_add(nxt.y, dy_pipe[MULT_LATENCY-1]);
            if (!nxt.hit)
                nxt.z = sat_add(nxt.z, dz_pipe[MULT_LATENCY-1]);
            nxt.sz = '0;
            nxt.sr = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < MULT_LATENCY; i++) begin
                bnd_pipe[i] <= rst_bundle();
                dx_pipe[i]  <= '0;
                dy_pipe[i]  <= '0;
                dz_pipe[i]  <= '0;
            end
            out_q     <= rst_bundle();
            hop_count <= '0;
        end else if (enable) begin
            bnd_pipe[0] <= in_b;
            dx_pipe[0]  <= qmul(ux_boundaryChecker, sr_boundaryChecker);
            dy_pipe[0]  <= qmul(uy_boundaryChecker, sr_boundaryChecker);
            dz_pipe[0]  <= qmul(uz_boundaryChecker, sz_boundaryChecker);
            for (int i = 1; i < MULT_LATENCY; i++) begin
                bnd_pipe[i] <= bnd_pipe[i-1];
                dx_pipe[i]  <= dx_pipe[i-1];
                dy_pipe[i]  <= dy_pipe[i-1];
                dz_pipe[i]  <= dz_pipe[i-1];
            end
            out_q <= nxt;
            if (!nxt.dead)
                hop_count <= hop_count + 32'd1;
        end
    end

    assign x_hop      = out_q.x;
    assign y_hop      = out_q.y;
    assign z_hop      = out_q.z;
    assign ux_hop     = out_q.ux;
    assign uy_hop     = out_q.uy;
    assign uz_hop     = out_q.uz;
    assign sz_hop     = out_q.sz;
    assign sr_hop     = out_q.sr;
    assign sleftz_hop = out_q.sleftz;
    assign sleftr_hop = out_q.sleftr;
    assign layer_hop  = out_q.layer;
    assign weight_hop = out_q.weight;
    assign dead_hop   = out_q.dead;
    assign hit_hop    = out_q.hit;
endmodule

// File: tb/tb_hop_stage.sv
// Randomized bench for hop_stage against a queue-based delay model with
// wide-integer position arithmetic.
module tb_hop_stage;
    localparam int ML = 1;

    typedef struct {
        int       x, y, z, ux, uy, uz, sz, sr, sleftz, sleftr;
        bit [2:0] layer;
        int       weight;
        bit       dead, hit;
    } ph_t;

    logic        clock, reset, enable;
    logic [31:0] x_i, y_i, z_i, ux_i, uy_i, uz_i, sz_i, sr_i, slz_i, slr_i, w_i;
    logic [2:0]  layer_i;
    logic        dead_i, hit_i;
    logic [31:0] x_hop, y_hop, z_hop, ux_hop, uy_hop, uz_hop, sz_hop, sr_hop;
    logic [31:0] sleftz_hop, sleftr_hop, weight_hop, hop_count;
    logic [2:0]  layer_hop;
    logic        dead_hop, hit_hop;

    hop_stage #(.MULT_LATENCY(ML)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .x_boundaryChecker(x_i), .y_boundaryChecker(y_i), .z_boundaryChecker(z_i),
        .ux_boundaryChecker(ux_i), .uy_boundaryChecker(uy_i), .uz_boundaryChecker(uz_i),
        .sz_boundaryChecker(sz_i), .sr_boundaryChecker(sr_i),
        .sleftz_boundaryChecker(slz_i), .sleftr_boundaryChecker(slr_i),
        .layer_boundaryChecker(layer_i), .weight_boundaryChecker(w_i),
        .dead_boundaryChecker(dead_i), .hit_boundaryChecker(hit_i),
        .x_hop(x_hop), .y_hop(y_hop), .z_hop(z_hop),
        .ux_hop(ux_hop), .uy_hop(uy_hop), .uz_hop(uz_hop),
        .sz_hop(sz_hop), .sr_hop(sr_hop), .sleftz_hop(sleftz_hop), .sleftr_hop(sleftr_hop),
        .layer_hop(layer_hop), .weight_hop(weight_hop),
        .dead_hop(dead_hop), .hit_hop(hit_hop), .hop_count(hop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          errors = 0, checks = 0;
    ph_t         mq[$];
    ph_t         exp_o;
    int unsigned exp_cnt;
    ph_t         RST;

    function automatic int sat(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return int'(v);
    endfunction

    // Position advance: real-valued step scaled by 2^-31, floored.
    function automatic ph_t hop(input ph_t p);
        ph_t r = p;
        if (p.dead) return p;
        r.x = sat(longint'(p.x) + ((longint'(p.ux) * longint'(p.sr)) >>> 31));
        r.y = sat(longint'(p.y) + ((longint'(p.uy) * longint'(p.sr)) >>> 31));
        if (!p.hit)
            r.z = sat(longint'(p.z) + ((longint'(p.uz) * longint'(p.sz)) >>> 31));
        r.sz = 0;
        r.sr = 0;
        return r;
    endfunction

    function automatic logic [356:0] mvec(input ph_t p);
        return {p.x, p.y, p.z, p.ux, p.uy, p.uz, p.sz, p.sr, p.sleftz, p.sleftr,
                p.layer, p.weight, p.dead, p.hit};
    endfunction

    function automatic logic [356:0] dvec();
        return {x_hop, y_hop, z_hop, ux_hop, uy_hop, uz_hop, sz_hop, sr_hop,
                sleftz_hop, sleftr_hop, layer_hop, weight_hop, dead_hop, hit_hop};
    endfunction

    function automatic ph_t rnd_ph();
        ph_t p;
        p.x = $urandom; p.y = $urandom; p.z = $urandom;
        p.ux = $urandom; p.uy = $urandom; p.uz = $urandom;
        p.sz = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 5000);
        p.sr = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 5000);
        p.sleftz = $urandom; p.sleftr = $urandom;
        p.layer = 3'($urandom); p.weight = $urandom;
        p.dead = ($urandom_range(0, 3) == 0);
        p.hit  = ($urandom_range(0, 2) == 0);
        return p;
    endfunction

    function automatic ph_t basic_ph();
        ph_t p;
        p = '{x: 1000, y: 1000, z: 1000, ux: 32'h4000_0000, uy: 32'hC000_0000,
              uz: 32'h2000_0000, sz: 200, sr: 100, sleftz: 7, sleftr: 9,
              layer: 3'd2, weight: 32'h1234, dead: 1'b0, hit: 1'b0};
        return p;
    endfunction

    // Drive at negedge, advance one edge, update the model, return at negedge.
    task automatic step(input ph_t p, input bit en, input bit rn);
        x_i = p.x; y_i = p.y; z_i = p.z; ux_i = p.ux; uy_i = p.uy; uz_i = p.uz;
        sz_i = p.sz; sr_i = p.sr; slz_i = p.sleftz; slr_i = p.sleftr;
        layer_i = p.layer; w_i = p.weight; dead_i = p.dead; hit_i = p.hit;
        enable = en; reset = rn;
        @(posedge clock);
        if (!rn) begin
            mq.delete();
            for (int i = 0; i < ML; i++) mq.push_back(RST);
            exp_o = RST;
            exp_cnt = 0;
        end else if (en) begin
            ph_t h;
            h = mq.pop_front();
            exp_o = hop(h);
            if (!h.dead) exp_cnt++;
            mq.push_back(p);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(rnd_ph(), 1'($urandom), 1'b0);
        checks++;
        if (dvec() !== mvec(RST)) begin
            errors++; $display("FAIL reset_bundle: got %h want %h", dvec(), mvec(RST));
        end
        checks++;
        if (hop_count !== 32'd0 || dead_hop !== 1'b1 || hit_hop !== 1'b0) begin
            errors++; $display("FAIL reset_flags: cnt=%0d dead=%b hit=%b want 0/1/0", hop_count, dead_hop, hit_hop);
        end
    endtask

    task automatic test_basic();
        ph_t idle = RST;
        step(basic_ph(), 1'b1, 1'b1);
        checks++;
        if (dead_hop !== 1'b1 || hop_count !== 32'd0) begin
            errors++; $display("FAIL basic_early: dead=%b cnt=%0d want 1/0", dead_hop, hop_count);
        end
        step(idle, 1'b1, 1'b1);
        checks++;
        if (x_hop !== 32'd1050 || y_hop !== 32'd950 || sz_hop !== 0 || sr_hop !== 0 || hop_count !== 32'd1) begin
            errors++; $display("FAIL basic_hop: x=%0d y=%0d sz=%0d sr=%0d cnt=%0d want 1050/950/0/0/1", x_hop, y_hop, sz_hop, sr_hop, hop_count);
        end
        checks++;
        if (dvec() !== mvec(exp_o)) begin
            errors++; $display("FAIL basic_bundle: got %h want %h", dvec(), mvec(exp_o));
        end
    endtask

    task automatic test_hit();
        ph_t p = basic_ph();
        p.hit = 1'b1; p.z = 5000;
        step(p, 1'b1, 1'b1);
        step(RST, 1'b1, 1'b1);
        checks++;
        if (z_hop !== 32'd5000 || x_hop !== 32'd1050 || y_hop !== 32'd950 || hit_hop !== 1'b1) begin
            errors++; $display("FAIL hit_hop: z=%0d x=%0d y=%0d hit=%b want 5000/1050/950/1", z_hop, x_hop, y_hop, hit_hop);
        end
    endtask

    task automatic test_saturation();
        ph_t p = basic_ph();
        p.x = 32'h7FFF_FFF0; p.ux = 32'h7FFF_FFFF; p.sr = 32'h100;
        step(p, 1'b1, 1'b1);
        p.x = 32'h8000_0010; p.ux = 32'h8000_0000;
        step(p, 1'b1, 1'b1);
        checks++;
        if (x_hop !== 32'h7FFF_FFFF) begin
            errors++; $display("FAIL sat_pos: got %h want 7fffffff", x_hop);
        end
        step(RST, 1'b1, 1'b1);
        checks++;
        if (x_hop !== 32'h8000_0000) begin
            errors++; $display("FAIL sat_neg: got %h want 80000000", x_hop);
        end
    endtask

    task automatic test_stall();
        ph_t p = basic_ph();
        int unsigned c0;
        p.x = 2000;
        step(p, 1'b1, 1'b1);
        c0 = hop_count;
        for (int i = 0; i < 5; i++) begin
            step(rnd_ph(), 1'b0, 1'b1);
            checks++;
            if (dvec() !== mvec(exp_o) || hop_count !== c0) begin
                errors++; $display("FAIL stall_hold: got %h cnt=%0d want %h cnt=%0d", dvec(), hop_count, mvec(exp_o), c0);
            end
        end
        step(RST, 1'b1, 1'b1);
        checks++;
        if (x_hop !== 32'd2050 || hop_count !== c0 + 1) begin
            errors++; $display("FAIL stall_emerge: x=%0d cnt=%0d want 2050/%0d", x_hop, hop_count, c0 + 1);
        end
    endtask

    task automatic test_dead();
        ph_t p = basic_ph();
        int unsigned c0;
        p.dead = 1'b1;
        c0 = hop_count;
        step(p, 1'b1, 1'b1);
        step(RST, 1'b1, 1'b1);
        checks++;
        if (dvec() !== mvec(p) || sr_hop !== 32'd100 || hop_count !== c0) begin
            errors++; $display("FAIL dead_pass: got %h cnt=%0d want %h cnt=%0d", dvec(), hop_count, mvec(p), c0);
        end
    endtask

    task automatic test_reset_midflight();
        step(basic_ph(), 1'b1, 1'b1);
        step(RST, 1'b1, 1'b0);
        checks++;
        if (dead_hop !== 1'b1 || hop_count !== 32'd0) begin
            errors++; $display("FAIL midreset: dead=%b cnt=%0d want 1/0", dead_hop, hop_count);
        end
        for (int i = 0; i < 3; i++) step(RST, 1'b1, 1'b1);
        checks++;
        if (dead_hop !== 1'b1 || hop_count !== 32'd0 || x_hop !== 32'd0) begin
            errors++; $display("FAIL midreset_drop: dead=%b cnt=%0d x=%0d want 1/0/0", dead_hop, hop_count, x_hop);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(rnd_ph(), ($urandom_range(0, 4) != 0), ($urandom_range(0, 60) != 0));
            checks++;
            if (dvec() !== mvec(exp_o) || hop_count !== exp_cnt) begin
                errors++; $display("FAIL random[%0d]: got %h cnt=%0d want %h cnt=%0d", i, dvec(), hop_count, mvec(exp_o), exp_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        ph_t a, b;
        a = basic_ph(); b = basic_ph();
        a.x = 10; b.x = 20; b.ux = 32'h2000_0000;
        step(a, 1'b1, 1'b1);
        step(b, 1'b1, 1'b1);
        checks++;
        if (x_hop !== 32'd60) begin
            errors++; $display("FAIL b2b_first: got %0d want 60", x_hop);
        end
        step(RST, 1'b1, 1'b1);
        checks++;
        if (x_hop !== 32'd45 || dvec() !== mvec(exp_o)) begin
            errors++; $display("FAIL b2b_second: got %0d want 45", x_hop);
        end
    endtask

    initial begin
        RST = '{default: 0, layer: 3'd0, dead: 1'b1, hit: 1'b0};
        for (int i = 0; i < ML; i++) mq.push_back(RST);
        exp_o = RST; exp_cnt = 0;
        reset = 1'b0; enable = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_hit();
        test_saturation();
        test_stall();
        test_dead();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
